// File: rtl/mem_arbiter16_pkg.sv
// Shared definitions for the two-master memory arbiter: state encoding,
// default widths and master index constants.
package mem_arbiter16_pkg;

   localparam int AW_DEF = 16;
   localparam int DW_DEF = 16;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ACK    = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter16_pick2.sv
// Combinational two-way winner select: a lone requester wins; on a tie either
// fixed priority (m0) or round-robin against the previous winner.
module arb_pick2
   import mem_arbiter16_pkg::*;
#(
   parameter bit RR = 1'b1
) (
   input  logic req0,
   input  logic req1,
   input  logic last,
   output logic grant,
   output logic valid
);

   always_comb begin
      valid = req0 | req1;
      grant = M0;
      if (req0 && req1)
         grant = RR ? ~last : M0;
      else if (req1)
         grant = M1;
   end

endmodule

// File: rtl/mem_arbiter16.sv
// Two-master arbiter in front of a single-port async-read memory. Each
// transaction runs IDLE -> ACCESS -> ACK, with a one-cycle ack to the owner.
module mem_arbiter16
   import mem_arbiter16_pkg::*;
#(
   parameter int AW = AW_DEF,
   parameter int DW = DW_DEF,
   parameter bit RR = 1'b1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          m0_req,
   input  logic [AW-1:0] m0_addr,
   input  logic [DW-1:0] m0_wdata,
   input  logic          m0_write,
   output logic          m0_ack,
   output logic [DW-1:0] m0_rdata,
   input  logic          m1_req,
   input  logic [AW-1:0] m1_addr,
   input  logic [DW-1:0] m1_wdata,
   input  logic          m1_write,
   output logic          m1_ack,
   output logic [DW-1:0] m1_rdata,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_write,
   input  logic [DW-1:0] mem_rdata
);

   arb_state_t state, state_nxt;
   logic       owner;
   logic       last;
   logic       gnt;
   logic       gnt_vld;

   arb_pick2 #(.RR(RR)) u_pick (
      .req0  (m0_req),
      .req1  (m1_req),
      .last  (last),
      .grant (gnt),
      .valid (gnt_vld)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Requests are only looked at in IDLE; ACCESS and ACK always advance.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (gnt_vld) state_nxt = ST_ACCESS;
         ST_ACCESS: state_nxt = ST_ACK;
         ST_ACK:    state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // last resets to m1 so the first tie under round-robin goes to m0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         owner     <= M0;
         last      <= M1;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_write <= 1'b0;
         m0_ack    <= 1'b0;
         m1_ack    <= 1'b0;
         m0_rdata  <= '0;
         m1_rdata  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (gnt_vld) begin
                  owner     <= gnt;
                  last      <= gnt;
                  mem_addr  <= (gnt == M1) ? m1_addr  : m0_addr;
                  mem_wdata <= (gnt == M1) ? m1_wdata : m0_wdata;
                  mem_write <= (gnt == M1) ? m1_write : m0_write;
               end
            end
            ST_ACCESS: begin
               // mem_write still reflects the transaction type here
               if (!mem_write) begin
                  if (owner == M1) m1_rdata <= mem_rdata;
                  else             m0_rdata <= mem_rdata;
               end
               if (owner == M1) m1_ack <= 1'b1;
               else             m0_ack <= 1'b1;
               mem_write <= 1'b0;
            end
            ST_ACK: begin
               m0_ack <= 1'b0;
               m1_ack <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter16.sv
// Directed bench for mem_arbiter16: a round-robin instance (a_*) backed by a
// memory model, plus a fixed-priority instance (b_*) sharing the same stimulus.
module tb_mem_arbiter16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        m0_req = 1'b0, m1_req = 1'b0;
   logic [15:0] m0_addr = '0, m1_addr = '0;
   logic [15:0] m0_wdata = '0, m1_wdata = '0;
   logic        m0_write = 1'b0, m1_write = 1'b0;

   logic        a_m0_ack, a_m1_ack, a_mem_write;
   logic [15:0] a_m0_rdata, a_m1_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
   logic        b_m0_ack, b_m1_ack, b_mem_write;
   logic [15:0] b_m0_rdata, b_m1_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

   logic [15:0] mem [0:65535];

   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   mem_arbiter16 #(.AW(16), .DW(16), .RR(1'b1)) u_rr (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_write(m0_write),
      .m0_ack(a_m0_ack), .m0_rdata(a_m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_write(m1_write),
      .m1_ack(a_m1_ack), .m1_rdata(a_m1_rdata),
      .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_write(a_mem_write),
      .mem_rdata(a_mem_rdata)
   );

   mem_arbiter16 #(.AW(16), .DW(16), .RR(1'b0)) u_fp (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_write(m0_write),
      .m0_ack(b_m0_ack), .m0_rdata(b_m0_rdata),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_write(m1_write),
      .m1_ack(b_m1_ack), .m1_rdata(b_m1_rdata),
      .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_write(b_mem_write),
      .mem_rdata(b_mem_rdata)
   );

   assign a_mem_rdata = mem[a_mem_addr];
   assign b_mem_rdata = mem[b_mem_addr];

   // Memory model: preload, then accept writes from the round-robin instance only.
   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hA5A5;
      mem[16'h0010] = 16'h1234;
      mem[16'h0020] = 16'h5678;
      mem[16'h8001] = 16'h0000;
      mem[16'h0030] = 16'h0000;
      forever begin
         @(posedge clk);
         if (a_mem_write) mem[a_mem_addr] = a_mem_wdata;
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   int rr_who[4], rr_at[4], fp_who[4];
   int rr_n, fp_n;
   int rr_exp_who[4] = '{0, 1, 0, 1};
   int rr_exp_at[4]  = '{2, 5, 8, 11};
   logic acc;

   initial begin
      // reset state
      tick; tick;
      chk("rst_mem_addr",  32'(a_mem_addr), 32'h0);
      chk("rst_mem_wdata", 32'(a_mem_wdata), 32'h0);
      chk("rst_mem_write", 32'(a_mem_write), 32'h0);
      chk("rst_m0_ack",    32'(a_m0_ack), 32'h0);
      chk("rst_m1_ack",    32'(a_m1_ack), 32'h0);
      chk("rst_m0_rdata",  32'(a_m0_rdata), 32'h0);
      chk("rst_m1_rdata",  32'(a_m1_rdata), 32'h0);
      @(negedge clk) reset = 1'b0;

      // m0 read of 0x0010
      @(negedge clk);
      m0_req = 1'b1; m0_addr = 16'h0010; m0_write = 1'b0;
      tick;
      chk("rd_access_addr", 32'(a_mem_addr), 32'h0010);
      chk("rd_access_wr",   32'(a_mem_write), 32'h0);
      chk("rd_early_ack",   32'(a_m0_ack), 32'h0);
      tick;
      chk("rd_ack",       32'(a_m0_ack), 32'h1);
      chk("rd_data",      32'(a_m0_rdata), 32'h1234);
      chk("rd_m1_ack",    32'(a_m1_ack), 32'h0);
      chk("rd_m1_rdata",  32'(a_m1_rdata), 32'h0);
      chk("rd_fp_ack",    32'(b_m0_ack), 32'h1);
      @(negedge clk) m0_req = 1'b0;
      tick;
      chk("rd_ack_pulse", 32'(a_m0_ack), 32'h0);
      chk("rd_data_held", 32'(a_m0_rdata), 32'h1234);
      chk("rd_addr_held", 32'(a_mem_addr), 32'h0010);
      tick;

      // m1 write 0x8001 <- 0xBEEF
      @(negedge clk);
      m1_req = 1'b1; m1_addr = 16'h8001; m1_wdata = 16'hBEEF; m1_write = 1'b1;
      tick;
      chk("wr_strobe", 32'(a_mem_write), 32'h1);
      chk("wr_addr",   32'(a_mem_addr), 32'h8001);
      chk("wr_data",   32'(a_mem_wdata), 32'hBEEF);
      chk("wr_early_ack", 32'(a_m1_ack), 32'h0);
      tick;
      chk("wr_strobe_1cyc", 32'(a_mem_write), 32'h0);
      chk("wr_ack",         32'(a_m1_ack), 32'h1);
      chk("wr_rdata_kept",  32'(a_m1_rdata), 32'h0);
      chk("wr_landed",      32'(mem[16'h8001]), 32'hBEEF);
      chk("wr_m0_rdata",    32'(a_m0_rdata), 32'h1234);
      @(negedge clk) m1_req = 1'b0;
      tick;
      chk("wr_ack_pulse",   32'(a_m1_ack), 32'h0);
      chk("wr_wdata_held",  32'(a_mem_wdata), 32'hBEEF);

      // m1 drops req during ACCESS; the write still completes
      @(negedge clk);
      m1_req = 1'b1; m1_addr = 16'h0030; m1_wdata = 16'hCAFE; m1_write = 1'b1;
      tick;
      @(negedge clk) m1_req = 1'b0;
      tick;
      chk("drop_ack",    32'(a_m1_ack), 32'h1);
      chk("drop_landed", 32'(mem[16'h0030]), 32'hCAFE);
      // m0 raises req only during ACK and drops it before any IDLE edge
      @(negedge clk);
      m0_req = 1'b1; m0_addr = 16'h0050; m0_write = 1'b0;
      tick;
      @(negedge clk) m0_req = 1'b0;
      acc = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         acc = acc | a_m0_ack | a_mem_write;
      end
      chk("withdraw_no_txn", 32'(acc), 32'h0);
      chk("withdraw_addr",   32'(a_mem_addr), 32'h0030);

      // reset during ACCESS of a write
      @(negedge clk);
      m0_req = 1'b1; m0_addr = 16'h0040; m0_wdata = 16'h1111; m0_write = 1'b1;
      tick;
      chk("rstmid_strobe", 32'(a_mem_write), 32'h1);
      #2 reset = 1'b1; m0_req = 1'b0;
      #1;
      chk("rstmid_write_async", 32'(a_mem_write), 32'h0);
      chk("rstmid_addr_async",  32'(a_mem_addr), 32'h0);
      chk("rstmid_ack_async",   32'(a_m0_ack), 32'h0);
      @(negedge clk);
      @(negedge clk) reset = 1'b0;
      acc = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         acc = acc | a_m0_ack | a_m1_ack;
      end
      chk("rstmid_no_ack", 32'(acc), 32'h0);
      // fresh transaction shows the FSM restarted from IDLE
      @(negedge clk);
      m1_req = 1'b1; m1_addr = 16'h0020; m1_write = 1'b0;
      tick;
      chk("post_rst_addr", 32'(a_mem_addr), 32'h0020);
      chk("post_rst_early", 32'(a_m1_ack), 32'h0);
      tick;
      chk("post_rst_ack",   32'(a_m1_ack), 32'h1);
      chk("post_rst_rdata", 32'(a_m1_rdata), 32'h5678);
      @(negedge clk) m1_req = 1'b0;
      tick;

      // sustained contention, both instances from a common reset
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m0_req = 1'b1; m0_addr = 16'h0010; m0_write = 1'b0;
      m1_req = 1'b1; m1_addr = 16'h0020; m1_write = 1'b0;
      rr_n = 0; fp_n = 0;
      for (int c = 1; c <= 12; c++) begin
         tick;
         if (a_m0_ack || a_m1_ack) begin
            if (rr_n < 4) begin
               rr_who[rr_n] = a_m1_ack ? 1 : 0;
               rr_at[rr_n]  = c;
            end
            rr_n++;
         end
         if (b_m0_ack || b_m1_ack) begin
            if (fp_n < 4) fp_who[fp_n] = b_m1_ack ? 1 : 0;
            fp_n++;
         end
      end
      @(negedge clk);
      m0_req = 1'b0; m1_req = 1'b0;
      chk("rr_count", 32'(rr_n), 32'd4);
      chk("fp_count", 32'(fp_n), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rr_order%0d", i), 32'(rr_who[i]), 32'(rr_exp_who[i]));
         chk($sformatf("rr_cycle%0d", i), 32'(rr_at[i]), 32'(rr_exp_at[i]));
         chk($sformatf("fp_order%0d", i), 32'(fp_who[i]), 32'd0);
      end
      chk("rr_m0_rdata", 32'(a_m0_rdata), 32'h1234);
      chk("rr_m1_rdata", 32'(a_m1_rdata), 32'h5678);
      chk("fp_m1_starved", 32'(b_m1_rdata), 32'h0);
      tick; tick;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
